// File: rtl/code_conv_pkg.sv
// Shared constants for the code converter: mode encodings and nibble limits
// used by the BCD / Excess-3 conversions.
package code_conv_pkg;

  // Per-beat conversion mode, carried alongside the data word.
  localparam logic [1:0] MODE_B2G     = 2'b00;
  localparam logic [1:0] MODE_G2B     = 2'b01;
  localparam logic [1:0] MODE_BCD2XS3 = 2'b10;
  localparam logic [1:0] MODE_XS32BCD = 2'b11;

  // Nibble-level constants for BCD <-> Excess-3.
  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage : code_conv_pkg

// File: rtl/code_conv_core.sv
// Purely combinational code converter: (data, mode) -> (result, err).
// Usable stand-alone as the unpipelined converter. An invalid BCD or XS3
// nibble anywhere in the word flags the whole word and forces result to 0.
module code_conv_core
  import code_conv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int NIBBLES = WIDTH / 4;

  // Convert the whole word according to mode; any bad nibble zeroes the result.
  always_comb begin
    logic [3:0] nib;
    // NOTE: every output and temporary gets a default before the case so no
    // path through this block can leave a value unassigned (which would infer a latch).
    result = '0;
    err    = 1'b0;
    nib    = '0;
    case (mode)
      MODE_B2G: begin
        result = data ^ (data >> 1);
      end
      MODE_G2B: begin
        result[WIDTH-1] = data[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
          result[i] = result[i+1] ^ data[i];
        end
      end
      MODE_BCD2XS3: begin
        for (int n = 0; n < NIBBLES; n++) begin
          nib = data[4*n +: 4];
          if (nib > BCD_MAX) err = 1'b1;
          result[4*n +: 4] = nib + XS3_OFFSET;
        end
      end
      MODE_XS32BCD: begin
        for (int n = 0; n < NIBBLES; n++) begin
          nib = data[4*n +: 4];
          if (nib < XS3_MIN || nib > XS3_MAX) err = 1'b1;
          result[4*n +: 4] = nib - XS3_OFFSET;
        end
      end
    endcase
    if (err) result = '0;
  end

endmodule : code_conv_core

// File: rtl/code_conv_pipe.sv
// Two-stage valid/ready code converter. Stage 1 captures the raw word and its
// mode; the combinational core sits between stage 1 and stage 2; stage 2 holds
// the converted word and error flag and drives the outputs directly.
// Full backpressure, no bubbles while out_ready is high, and a saturating
// count of errored beats delivered downstream.
module code_conv_pipe
  import code_conv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1: raw beat
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [1:0]       s1_mode_q,  s1_mode_d;
  // Stage 2: converted beat
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_err_q,   s2_err_d;
  // Error counter
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

  logic             s1_load, s2_load;
  logic [WIDTH-1:0] core_result;
  logic             core_err;

  code_conv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data   (s1_data_q),
    .mode   (s1_mode_q),
    .result (core_result),
    .err    (core_err)
  );

  // Advance control and next-state for both stages and the error counter.
  always_comb begin
    s2_load = !s2_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      // Data and mode are only captured for a real beat, so idle-bus X never enters.
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = in_mode;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = core_result;
        s2_err_d  = core_err;
      end
    end

    err_cnt_d = err_cnt_q;
    if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards every in-flight beat and clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, because out_data must read 0
      // out of reset and the stage-1 word feeds the core combinationally.
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_B2G;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

endmodule : code_conv_pipe
